// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Used by the FIFO, the bus interface and the uart_tx_wrapper top.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_wrapper_if.sv
// Host-side write port and status/serial outputs of the UART transmitter.
// The master modport is the host; the slave modport is the transmitter.
interface uart_tx_wrapper_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] WriteData;
    logic                   WriteEnable;
    logic                   FifoFull;
    logic                   Overflow;
    logic                   Busy;
    logic                   SDO;

    modport master (
        output WriteData, WriteEnable,
        input  FifoFull, Overflow, Busy, SDO
    );

    modport slave (
        input  WriteData, WriteEnable,
        output FifoFull, Overflow, Busy, SDO
    );

endinterface

// File: rtl/uart_tx_wrapper_fifo.sv
// Single-clock byte FIFO with first-word-fall-through read data.
// Pointers wrap naturally; count is one bit wider than the pointers.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_wrapper.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed shifter.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1 frames).
module uart_tx_wrapper
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic Clock,
    input  logic Reset_n,
    uart_tx_wrapper_if.slave bus
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    tx_state_t              state;
    logic [CW-1:0]          cnt;
    logic [2:0]             idx;
    logic [UART_DATA_W-1:0] shift;
    logic [UART_DATA_W-1:0] rdata;
    logic [AW:0]            count;
    logic                   sdo;
    logic                   sdo_next;
    logic                   busy;
    logic                   ovf;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   last;

    assign last = (cnt == CW'(CPB - 1));
    assign push = bus.WriteEnable & ~full;
    assign pop  = ~empty & ((state == IDLE) | ((state == STOP) & last));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clock),
        .rst_n (Reset_n),
        .push  (push),
        .wdata (bus.WriteData),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef UART_TX_PARITY_EN
    logic par;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)  par <= 1'b0;
        else if (pop)  par <= ^rdata;
    end
`endif

    // Line level follows the state one cycle late, giving the 2-edge latency.
    always_comb begin
        sdo_next = 1'b1;
        unique case (state)
            START:   sdo_next = 1'b0;
            DATA:    sdo_next = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  sdo_next = par;
`endif
            default: sdo_next = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            sdo   <= 1'b1;
            busy  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            sdo  <= sdo_next;
            busy <= (state != IDLE) | (count != '0);
            ovf  <= bus.WriteEnable & full;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pop) begin
                        shift <= rdata;
                        state <= START;
                    end
                end
                START: begin
                    if (last) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= DATA;
                    end else cnt <= cnt + 1'b1;
                end
                DATA: begin
                    if (last) begin
                        cnt   <= '0;
                        shift <= shift >> 1;
                        idx   <= idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                        if (idx == 3'd7) state <= PARITY;
`else
                        if (idx == 3'd7) state <= STOP;
`endif
                    end else cnt <= cnt + 1'b1;
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else cnt <= cnt + 1'b1;
                end
`endif
                STOP: begin
                    if (last) begin
                        cnt <= '0;
                        if (pop) begin
                            shift <= rdata;
                            state <= START;
                        end else state <= IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.FifoFull = full;
    assign bus.Overflow = ovf;
    assign bus.Busy     = busy;
    assign bus.SDO      = sdo;

endmodule

// File: tb/tb_uart_tx_wrapper.sv
// Scoreboard bench for uart_tx_wrapper: CLKS_PER_BIT=8, FIFO_DEPTH=4.
// Build with UART_TX_PARITY_EN defined to also cover the parity frame.
module tb_uart_tx_wrapper;
    import uart_pkg::*;

    localparam int CLK_FREQ = 8;
    localparam int BAUD     = 1;
    localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 88;
`else
    localparam int FRAME = 80;
`endif
    localparam time T_FRAME = FRAME * 10;

    typedef struct {
        logic [7:0] data;
        logic       st;
        logic       pb;
        logic       sp;
        time        t;
    } frame_t;

    logic Clock = 1'b0;
    logic Reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    frame_t     rx_q[$];
    logic [7:0] exp_q[$];

    uart_tx_wrapper_if bus ();

    uart_tx_wrapper #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    // Frame capture: first low sample, then bit centres every 8 cycles.
    initial begin : monitor
        frame_t f;
        forever begin
            @(negedge Clock);
            if (Reset_n && bus.SDO === 1'b0) begin
                f.t = $time;
                repeat (3) @(negedge Clock);
                f.st = bus.SDO;
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge Clock);
                    f.data[i] = bus.SDO;
                end
`ifdef UART_TX_PARITY_EN
                repeat (8) @(negedge Clock);
                f.pb = bus.SDO;
`else
                f.pb = 1'b0;
`endif
                repeat (8) @(negedge Clock);
                f.sp = bus.SDO;
                rx_q.push_back(f);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_byte(input logic [7:0] d, output time tw);
        @(negedge Clock);
        bus.WriteData   = d;
        bus.WriteEnable = 1'b1;
        @(posedge Clock);
        tw = $time;
    endtask

    task automatic drop_we();
        @(negedge Clock);
        bus.WriteEnable = 1'b0;
    endtask

    task automatic wait_frames(input int n, output bit ok);
        int b = 0;
        while (rx_q.size() < n && b < 3000) begin
            @(negedge Clock);
            b++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_until(input time t);
        while ($time < t) @(negedge Clock);
    endtask

    task automatic test_reset();
        int bad = 0;
        Reset_n         = 1'b0;
        bus.WriteEnable = 1'b0;
        bus.WriteData   = '0;
        repeat (3) @(negedge Clock);
        n_cmp++;
        if (bus.SDO !== 1'b1) begin
            n_bad++; $display("FAIL reset_sdo: got %b want 1", bus.SDO);
        end
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: got %b want 0", bus.Busy);
        end
        n_cmp++;
        if (bus.FifoFull !== 1'b0) begin
            n_bad++; $display("FAIL reset_full: got %b want 0", bus.FifoFull);
        end
        n_cmp++;
        if (bus.Overflow !== 1'b0) begin
            n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.Overflow);
        end
        Reset_n = 1'b1;
        repeat (100) begin
            @(negedge Clock);
            if (bus.SDO !== 1'b1 || bus.Busy !== 1'b0 || bus.FifoFull !== 1'b0)
                bad++;
        end
        n_cmp++;
        if (bad != 0 || rx_q.size() != 0) begin
            n_bad++;
            $display("FAIL idle_hold: got %0d bad cycles %0d frames want 0 0",
                     bad, rx_q.size());
        end
    endtask

    task automatic test_single();
        frame_t     f;
        logic [7:0] e;
        time        tw;
        bit         ok;
        exp_q.push_back(8'hA5);
        write_byte(8'hA5, tw);
        drop_we();
        wait_frames(1, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL single_timeout: got 0 frames want 1");
        end else begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if ({f.sp, f.data, f.st} !== {1'b1, e, 1'b0}) begin
                n_bad++;
                $display("FAIL single_bits: got %b want %b",
                         {f.sp, f.data, f.st}, {1'b1, e, 1'b0});
            end
            n_cmp++;
            if (f.t != tw + 25) begin
                n_bad++;
                $display("FAIL single_latency: got %0t want %0t", f.t, tw + 25);
            end
        end
        wait_until(tw + 20 + T_FRAME - 5);
        n_cmp++;
        if (bus.Busy !== 1'b1) begin
            n_bad++; $display("FAIL single_busy_end: got %b want 1", bus.Busy);
        end
        @(negedge Clock);
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_bad++; $display("FAIL single_busy_drop: got %b want 0", bus.Busy);
        end
    endtask

    task automatic test_back_to_back();
        frame_t     f1;
        frame_t     f2;
        logic [7:0] e;
        time        tw1;
        time        tw2;
        bit         ok;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        write_byte(8'h01, tw1);
        write_byte(8'hFF, tw2);
        drop_we();
        wait_frames(2, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL b2b_timeout: got %0d frames want 2", rx_q.size());
        end else begin
            f1 = rx_q.pop_front();
            e  = exp_q.pop_front();
            n_cmp++;
            if ({f1.sp, f1.data, f1.st} !== {1'b1, e, 1'b0}) begin
                n_bad++; $display("FAIL b2b_first: got %h want %h", f1.data, e);
            end
            f2 = rx_q.pop_front();
            e  = exp_q.pop_front();
            n_cmp++;
            if ({f2.sp, f2.data, f2.st} !== {1'b1, e, 1'b0}) begin
                n_bad++; $display("FAIL b2b_second: got %h want %h", f2.data, e);
            end
            n_cmp++;
            if (f2.t - f1.t != T_FRAME) begin
                n_bad++;
                $display("FAIL b2b_gap: got %0t want %0t", f2.t - f1.t, T_FRAME);
            end
        end
        wait_until(tw1 + 20 + 2 * T_FRAME - 5);
        n_cmp++;
        if (bus.Busy !== 1'b1) begin
            n_bad++; $display("FAIL b2b_busy_end: got %b want 1", bus.Busy);
        end
        @(negedge Clock);
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_busy_drop: got %b want 0", bus.Busy);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        frame_t     f;
        logic [7:0] e;
        time        tw;
        bit         ok;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(d[i]);
            write_byte(d[i], tw);
        end
        @(negedge Clock);
        n_cmp++;
        if (bus.FifoFull !== 1'b1 || bus.Overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_full: got full=%b ovf=%b want 1 0",
                     bus.FifoFull, bus.Overflow);
        end
        bus.WriteData = d[5];
        @(posedge Clock);
        drop_we();
        n_cmp++;
        if (bus.Overflow !== 1'b1) begin
            n_bad++; $display("FAIL ovf_pulse: got %b want 1", bus.Overflow);
        end
        @(negedge Clock);
        n_cmp++;
        if (bus.Overflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_one_cycle: got %b want 0", bus.Overflow);
        end
        wait_frames(5, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL ovf_timeout: got %0d frames want 5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                f = rx_q.pop_front();
                e = exp_q.pop_front();
                n_cmp++;
                if ({f.sp, f.data, f.st} !== {1'b1, e, 1'b0}) begin
                    n_bad++;
                    $display("FAIL ovf_frame%0d: got %h want %h", i, f.data, e);
                end
            end
        end
        repeat (FRAME + 20) @(negedge Clock);
        n_cmp++;
        if (rx_q.size() != 0 || bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_extra: got %0d frames busy=%b want 0 0",
                     rx_q.size(), bus.Busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        time tw;
        time tw2;
        int  bad = 0;
        write_byte(8'h3C, tw);
        write_byte(8'h55, tw2);
        drop_we();
        wait_until(tw + 20 + 160 + 45);
        n_cmp++;
        if (bus.SDO !== 1'b0 || bus.Busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: got sdo=%b busy=%b want 0 1", bus.SDO, bus.Busy);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.SDO !== 1'b1 || bus.Busy !== 1'b0 || bus.FifoFull !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_async: got sdo=%b busy=%b full=%b want 1 0 0",
                     bus.SDO, bus.Busy, bus.FifoFull);
        end
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (120) @(negedge Clock);
        rx_q.delete();
        exp_q.delete();
        repeat (200) begin
            @(negedge Clock);
            if (bus.SDO !== 1'b1 || bus.Busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || rx_q.size() != 0) begin
            n_bad++;
            $display("FAIL mid_residual: got %0d bad cycles %0d frames want 0 0",
                     bad, rx_q.size());
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        frame_t     f;
        logic [7:0] e;
        time        tw;
        bit         ok;
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        write_byte(8'h07, tw);
        write_byte(8'h03, tw);
        drop_we();
        wait_frames(2, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL par_timeout: got %0d frames want 2", rx_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                f = rx_q.pop_front();
                e = exp_q.pop_front();
                n_cmp++;
                if ({f.sp, f.pb, f.data, f.st} !== {1'b1, ^e, e, 1'b0}) begin
                    n_bad++;
                    $display("FAIL par_frame%0d: got %b want %b", i,
                             {f.sp, f.pb, f.data, f.st}, {1'b1, ^e, e, 1'b0});
                end
            end
        end
        repeat (FRAME + 20) @(negedge Clock);
    endtask
`endif

    initial begin
        bus.WriteData   = '0;
        bus.WriteEnable = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
